// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one pipelined 16x16 multiplier between NREQ requesters.
// A valid+ID tag pipe runs beside the multiplier to route each product home.
module mul_share_arbiter #(
    parameter int NREQ        = 4,
    parameter int MUL_LATENCY = 5,
    parameter int IDW         = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [16*NREQ-1:0]   req_a,
    input  logic [16*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [31:0]          mul_in,
    input  logic [31:0]          mul_out,
    output logic [NREQ-1:0]      resp_valid,
    output logic [15:0]          resp_data,
    output logic [2:0]           in_flight,
    output logic                 hi_err
);

    logic [IDW-1:0]                   rr_q, rr_d;
    logic [MUL_LATENCY-1:0]           tag_v_q, tag_v_d;
    logic [MUL_LATENCY-1:0][IDW-1:0]  tag_id_q, tag_id_d;
    logic [NREQ-1:0]                  resp_valid_q, resp_valid_d;
    logic [15:0]                      resp_data_q, resp_data_d;
    logic [2:0]                       in_flight_q, in_flight_d;
    logic                             hi_err_q, hi_err_d;

    logic [NREQ-1:0]                  grant;
    logic [IDW-1:0]                   gnt_id;
    logic [IDW-1:0]                   scan;
    logic                             hs;
    logic [31:0]                      mul_in_c;
    logic                             t_v;
    logic [IDW-1:0]                   t_id;

    // Scan starts just after the last winner; the first valid requester wins.
    always_comb begin
        grant    = '0;
        gnt_id   = '0;
        scan     = '0;
        hs       = 1'b0;
        mul_in_c = '0;
        for (int k = 1; k <= NREQ; k++) begin
            scan = IDW'((int'(rr_q) + k) % NREQ);
            if (!hs && req_valid[scan]) begin
                hs          = 1'b1;
                grant[scan] = 1'b1;
                gnt_id      = scan;
                mul_in_c    = {req_a[{scan, 4'b0000} +: 16],
                               req_b[{scan, 4'b0000} +: 16]};
            end
        end
    end

    assign t_v  = tag_v_q[MUL_LATENCY-1];
    assign t_id = tag_id_q[MUL_LATENCY-1];

    always_comb begin
        rr_d         = rr_q;
        tag_v_d      = {tag_v_q[MUL_LATENCY-2:0], hs};
        tag_id_d     = {tag_id_q[MUL_LATENCY-2:0], gnt_id};
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        in_flight_d  = in_flight_q;
        hi_err_d     = hi_err_q;
        if (hs) begin
            rr_d = gnt_id;
        end
        if (t_v) begin
            resp_valid_d = NREQ'(1) << t_id;
            resp_data_d  = mul_out[15:0];
            hi_err_d     = hi_err_q | (|mul_out[31:16]);
        end
        // Retire on the edge after the response pulse is visible.
        unique case ({hs, |resp_valid_q})
            2'b10:   in_flight_d = in_flight_q + 3'd1;
            2'b01:   in_flight_d = in_flight_q - 3'd1;
            default: in_flight_d = in_flight_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q         <= IDW'(NREQ - 1);
            tag_v_q      <= '0;
            tag_id_q     <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            in_flight_q  <= '0;
            hi_err_q     <= 1'b0;
        end else begin
            rr_q         <= rr_d;
            tag_v_q      <= tag_v_d;
            tag_id_q     <= tag_id_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            in_flight_q  <= in_flight_d;
            hi_err_q     <= hi_err_d;
        end
    end

    assign req_ready  = grant;
    assign mul_in     = mul_in_c;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign in_flight  = in_flight_q;
    assign hi_err     = hi_err_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: multiplier model, queue-based reference,
// directed literal checks and a randomized phase.
module tb_mul_share_arbiter;

    localparam int NREQ = 4;
    localparam int LAT  = 5;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [16*NREQ-1:0]   req_a = '0;
    logic [16*NREQ-1:0]   req_b = '0;
    logic [NREQ-1:0]      req_ready;
    logic [31:0]          mul_in;
    logic [31:0]          mul_out;
    logic [NREQ-1:0]      resp_valid;
    logic [15:0]          resp_data;
    logic [2:0]           in_flight;
    logic                 hi_err;
    logic                 force_hi = 1'b0;
    logic                 chk_on = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    mul_share_arbiter #(.NREQ(NREQ), .MUL_LATENCY(LAT), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .mul_in     (mul_in),
        .mul_out    (mul_out),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .in_flight  (in_flight),
        .hi_err     (hi_err)
    );

    always #5 clk = ~clk;

    // External multiplier: plain delay line, no reset, no valid.
    logic [31:0] mp [LAT];
    always @(posedge clk) begin
        for (int k = LAT - 1; k > 0; k--) mp[k] <= mp[k-1];
        mp[0] <= {16'h0000, 16'(32'(mul_in[31:16]) * 32'(mul_in[15:0]))};
    end
    assign mul_out = mp[LAT-1] | {15'h0, force_hi, 16'h0000};

    typedef struct {
        int          cyc;
        int          id;
        logic [15:0] a;
        logic [15:0] b;
    } rec_t;

    rec_t            q[$];
    int              m_rr;
    int              ecnt = 0;
    logic [NREQ-1:0] m_gnt_last;
    logic [NREQ-1:0] e_rv;
    logic [15:0]     e_rd;
    logic            e_hi;
    int              e_if;

    function automatic int pick(logic [NREQ-1:0] v, int rr);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
        end
        return -1;
    endfunction

    // Reference: ops live in a queue stamped with their acceptance edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rr       = NREQ - 1;
            q.delete();
            m_gnt_last = '0;
            e_rv       = '0;
            e_rd       = '0;
            e_hi       = 1'b0;
            e_if       = 0;
        end else begin
            int   g;
            rec_t r;
            ecnt++;
            g = pick(req_valid, m_rr);
            m_gnt_last = '0;
            if (g >= 0) begin
                r.cyc = ecnt;
                r.id  = g;
                r.a   = req_a[16*g +: 16];
                r.b   = req_b[16*g +: 16];
                q.push_back(r);
                m_rr = g;
                m_gnt_last[g] = 1'b1;
            end
            while (q.size() > 0 && q[0].cyc < ecnt - LAT) void'(q.pop_front());
            e_rv = '0;
            if (q.size() > 0 && q[0].cyc == ecnt - LAT) begin
                e_rv[q[0].id] = 1'b1;
                e_rd = 16'(32'(q[0].a) * 32'(q[0].b));
                if (force_hi) e_hi = 1'b1;
            end
            e_if = q.size();
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            int              g;
            logic [NREQ-1:0] er;
            logic [31:0]     em;
            g  = pick(req_valid, m_rr);
            er = '0;
            em = '0;
            if (g >= 0) begin
                er[g] = 1'b1;
                em = {req_a[16*g +: 16], req_b[16*g +: 16]};
            end
            chk("m_ready", 32'(req_ready), 32'(er));
            chk("m_mul_in", mul_in, em);
            chk("m_resp_valid", 32'(resp_valid), 32'(e_rv));
            chk("m_resp_data", 32'(resp_data), 32'(e_rd));
            chk("m_in_flight", 32'(in_flight), 32'(e_if));
            chk("m_hi_err", 32'(hi_err), 32'(e_hi));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [15:0] a, input logic [15:0] b);
        req_valid[i]     = v;
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    initial begin
        #2;
        do_reset();
        chk_on = 1'b1;
        tick();
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_in_flight", 32'(in_flight), 32'h0);
        chk("rst_hi_err", 32'(hi_err), 32'h0);

        // Single op from requester 0
        set_req(0, 1'b1, 16'd3, 16'd7);
        #1;
        chk("t1_ready", 32'(req_ready), 32'h1);
        chk("t1_mul_in", mul_in, 32'h0003_0007);
        tick();
        req_valid = '0;
        chk("t1_if1", 32'(in_flight), 32'd1);
        repeat (5) tick();
        chk("t1_rv", 32'(resp_valid), 32'h1);
        chk("t1_rd", 32'(resp_data), 32'd21);
        tick();
        chk("t1_if0", 32'(in_flight), 32'd0);
        chk("t1_rv0", 32'(resp_valid), 32'h0);

        // All requesters streaming
        do_reset();
        tick();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 16'(i + 1), 16'd10);
        for (int c = 1; c <= 12; c++) begin
            if (c <= 4) begin
                #1;
                chk("t2_ready", 32'(req_ready), 32'(1 << ((c - 1) % 4)));
            end
            tick();
            if (c >= 6 && c <= 9) begin
                chk("t2_rv", 32'(resp_valid), 32'(1 << (c - 6)));
                chk("t2_rd", 32'(resp_data), 32'(10 * (c - 5)));
            end
            if (c == 8) chk("t2_if_sat", 32'(in_flight), 32'd6);
        end
        req_valid = '0;
        repeat (10) tick();

        // Truncated product
        set_req(2, 1'b1, 16'hFFFF, 16'd2);
        tick();
        req_valid = '0;
        repeat (5) tick();
        chk("t3_rv", 32'(resp_valid), 32'h4);
        chk("t3_rd", 32'(resp_data), 32'hFFFE);
        chk("t3_hi", 32'(hi_err), 32'h0);
        repeat (3) tick();

        // Reset with ops in the pipe
        set_req(1, 1'b1, 16'd5, 16'd6);
        tick();
        set_req(1, 1'b1, 16'd6, 16'd6);
        tick();
        set_req(1, 1'b1, 16'd7, 16'd6);
        tick();
        req_valid = '0;
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t4_if", 32'(in_flight), 32'd0);
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("t4_no_rv", 32'(resp_valid), 32'h0);
        end
        set_req(3, 1'b1, 16'd9, 16'd9);
        #1;
        chk("t4_ready", 32'(req_ready), 32'h8);
        tick();
        req_valid = '0;
        repeat (5) tick();
        chk("t4_rv", 32'(resp_valid), 32'h8);
        chk("t4_rd", 32'(resp_data), 32'd81);
        repeat (2) tick();

        // hi_err: untagged force has no effect, tagged force is sticky
        force_hi = 1'b1;
        repeat (2) tick();
        force_hi = 1'b0;
        chk("t5_hi_untagged", 32'(hi_err), 32'h0);
        set_req(0, 1'b1, 16'd2, 16'd3);
        tick();
        req_valid = '0;
        repeat (4) tick();
        force_hi = 1'b1;
        tick();
        force_hi = 1'b0;
        chk("t5_hi_set", 32'(hi_err), 32'h1);
        chk("t5_rd", 32'(resp_data), 32'd6);
        repeat (5) tick();
        chk("t5_hi_sticky", 32'(hi_err), 32'h1);
        do_reset();
        chk("t5_hi_clr", 32'(hi_err), 32'h0);
        tick();

        // Rotation from rr=1 and idle hold
        set_req(1, 1'b1, 16'd1, 16'd1);
        tick();
        req_valid = '0;
        set_req(1, 1'b1, 16'd2, 16'd2);
        set_req(3, 1'b1, 16'd4, 16'd4);
        #1;
        chk("t6_ready3", 32'(req_ready), 32'h8);
        tick();
        req_valid[3] = 1'b0;
        #1;
        chk("t6_ready1", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        #1;
        chk("t6_idle_mul", mul_in, 32'h0);
        chk("t6_idle_ready", 32'(req_ready), 32'h0);
        repeat (3) tick();
        set_req(0, 1'b1, 16'd3, 16'd3);
        set_req(1, 1'b1, 16'd5, 16'd5);
        #1;
        chk("t6_rr_held", 32'(req_ready), 32'h1);
        tick();
        req_valid[0] = 1'b0;
        tick();
        req_valid = '0;
        repeat (8) tick();

        // Randomized traffic; a request holds until the model sees it granted
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || m_gnt_last[i]) begin
                    if ($urandom_range(0, 99) < 45)
                        set_req(i, 1'b1, 16'($urandom), 16'($urandom_range(0, 300)));
                    else
                        req_valid[i] = 1'b0;
                end
            end
            force_hi = ($urandom_range(0, 299) == 0);
            tick();
        end
        req_valid = '0;
        force_hi  = 1'b0;
        repeat (12) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one 5-stage pipelined 16x16 multiplier between NREQ independent requesters.
- Multiplier contract: {a,b} packed on a 32-bit input; 32-bit output = {16'h0000, (a*b)[15:0]}, valid exactly MUL_LATENCY edges after capture; no valid, stall or reset of its own.
- This block arbitrates requests round-robin, feeds the multiplier, and tracks a valid+ID tag alongside the pipe.
- Routes each truncated product back to its owning requester; sits between the Wishbone-side requester logic and the multiplier instance.

Parameters:
NREQ, 4, number of requesters (2..8)
MUL_LATENCY, 5, edges from multiplier input capture to result on mul_out
IDW, 2, requester ID width, equal to clog2(NREQ)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester operation valid
req_a  input  16*NREQ  operand a, requester i at [16i+15:16i]
req_b  input  16*NREQ  operand b, same packing
req_ready  output  NREQ  one-hot grant; handshake = valid&ready at edge
mul_in  output  32  to multiplier: {a,b} of granted requester, else 0
mul_out  input  32  from multiplier
resp_valid  output  NREQ  one-hot, one-cycle pulse, no backpressure
resp_data  output  16  product for the requester flagged in resp_valid
in_flight  output  3  count of accepted ops not yet responded (0..MUL_LATENCY+1)
hi_err  output  1  sticky: mul_out[31:16] nonzero on a tagged result

Behaviour:
- Reset (async assert, sync release) clears:
  - rr pointer, pointing at requester NREQ-1 so requester 0 has first priority
  - all tag stages invalid
  - resp_valid=0, resp_data=0, in_flight=0, hi_err=0
- Operations in the multiplier when reset asserts are discarded; their results must never produce resp_valid.
- Arbitration, combinational each cycle:
  - Search order starts at rr+1 and wraps modulo NREQ.
  - req_ready has at most one bit set: the first requester found with req_valid=1. No grant if none is valid.
  - At most one issue per cycle, back-to-back issue allowed every cycle.
  - On handshake, rr <= granted index. With no handshake, rr holds.
  - req_ready never depends on other requesters' ready; requesters may drop valid only after handshake.
- mul_in = {req_a[g], req_b[g]} when granted, 32'h0 otherwise.
- Tag pipe: MUL_LATENCY stages of {v, id}.
  - Stage 0 captures {handshake, g} at the same edge the multiplier captures mul_in.
  - Stage k+1 <= stage k on every edge, with no stall.
- Response register, updated every edge from the last tag stage T:
  - resp_valid <= T.v ? onehot(T.id) : 0
  - resp_data <= T.v ? mul_out[15:0] : resp_data (holds when idle)
- Latency: counting the acceptance edge as edge 1, resp_valid is high in the cycle after edge MUL_LATENCY+1 (6 by default). Ordering is strictly issue order.
- in_flight:
  - +1 on handshake; -1 on each edge where resp_valid is set.
  - Both in the same edge: unchanged.
  - Never wraps; max MUL_LATENCY+1 at full throughput.
- hi_err <= 1 on any edge where T.v=1 and mul_out[31:16]!=0; cleared only by reset.
- Product is the low 16 bits of the unsigned a*b; overflow is silently truncated, as defined by the multiplier.

Test Plan:
- Reset, then requester 0 issues a=3, b=7 once -> req_ready=4'b0001 that cycle; resp_valid=4'b0001 and resp_data=21 exactly 6 edges after acceptance; in_flight goes 1 then back to 0.
- All 4 requesters hold valid continuously with distinct operands (i: a=i+1, b=10) -> grants cycle 0,1,2,3,0,... one per cycle; responses 10,20,30,40 arrive in that order on consecutive cycles to the matching requester; in_flight saturates at 6.
- Requester 2 issues a=16'hFFFF, b=2 -> resp_data=16'hFFFE; mul_out[31:16] stays 0, so hi_err stays 0.
- Issue 3 back-to-back ops from requester 1, assert rst_n=0 two cycles later for one cycle -> no resp_valid ever pulses; in_flight=0; next op from requester 3 is granted first and responds normally.
- Force mul_out[31:16]=16'h0001 during one tagged result -> hi_err=1 and stays 1 until reset; force during an untagged cycle -> hi_err unchanged.
- Requesters 1 and 3 valid with rr=1 -> requester 3 granted; next cycle requester 1 granted; idle cycles -> mul_in=0 and rr unchanged.
